decode_sequencer: RTL and testbench
===================================

# decode_sequencer

Parametrised decode front-end between fetch and execute. It buffers fetched (already-decompressed) instructions in a small FIFO and classifies each one. It also expands multi-cycle instructions (JAL, JALR, branches) into an ordered sequence of micro-op steps using an internal step counter, so execute no longer supplies a cycle count. It adds a valid/ready handshake on both sides, a flush, and an RV32E/RV32I register-count mode.

## Interface
- REG_COUNT, 32: architectural register count, 16 (RV32E) or 32 (RV32I); sets the rs/rd output width to $clog2(REG_COUNT).
- DEPTH, 4: instruction FIFO entries, power of two, 2..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush_i  in  1  discard all buffered instructions and the in-progress sequence.
- instr_valid_i  in  1  fetch presents an instruction.
- instr_ready_o  out  1  the FIFO accepts an instruction this cycle.
- instr_i  in  32  decompressed instruction word.
- instr_addr_i  in  32  instruction PC.
- compressed_i  in  1  original encoding was 16-bit.
- uop_valid_o  out  1  the micro-op outputs are valid.
- uop_ready_i  in  1  execute consumes the micro-op.
- uop_class_o  out  3  0 ALU, 1 LOAD, 2 STORE, 3 JUMP, 4 BRANCH, 5 CSR, 6 SYSTEM, 7 ILLEGAL.
- uop_step_o  out  1  step index within the instruction.
- uop_last_o  out  1  final step of the instruction.
- rs1_o, rs2_o, rd_o  out  $clog2(REG_COUNT)  register indices, low bits of instr[19:15], [24:20], [11:7].
- imm_o  out  32  immediate for this step.
- pc_o  out  32  PC of the head instruction.
- funct3_o  out  3  instr[14:12], passed through.
- illegal_o  out  1  equals (uop_class_o == 7).

## Operation
- The FIFO stores {instr, addr, compressed}. A push occurs when instr_valid_i & instr_ready_o. instr_ready_o = !full & !flush_i & !rst.
- The head entry is decoded combinationally. uop_valid_o = !empty. A handshake occurs when uop_valid_o & uop_ready_i.
- On a handshake with uop_last_o=1: pop the entry and set step to 0. On a handshake with uop_last_o=0: step becomes 1.
- Two-step classes are JUMP (JAL, JALR) and legal BRANCH. All other classes, ILLEGAL included, take one step, so uop_last_o=1 at step 0.
- Class and immediate by opcode:
  - OP: ALU, imm 0.
  - OPIMM: ALU, I-imm; for funct3 001/101, imm = {27'b0, instr[24:20]}.
  - LUI/AUIPC: ALU, U-imm.
  - LOAD: LOAD, I-imm; funct3 011/110/111 is illegal.
  - STORE: STORE, S-imm; funct3 above 010 is illegal.
  - JAL/JALR: step 0 imm = compressed ? 2 : 4; step 1 imm = UJ-imm (JAL) or I-imm (JALR).
  - BRANCH: step 0 imm 0, step 1 SB-imm; funct3 010/011 is illegal.
  - SYSTEM with funct3≠0: CSR, imm = {27'b0, instr[19:15]}; funct3 100 is illegal.
  - SYSTEM with funct3=0: instr[31:20] must be 000, 001 or 302, else illegal; class SYSTEM, imm 0.
  - Any other opcode is illegal.
- RV32E check: with REG_COUNT=16, an instruction is ILLEGAL if any register field it uses has bit 4 set.
  - rd is used by OP, OPIMM, LUI, AUIPC, LOAD, JAL, JALR and CSR.
  - rs1 is used by OP, OPIMM, LOAD, STORE, JALR, BRANCH and register-form CSR.
  - rs2 is used by OP, STORE and BRANCH.
- An ILLEGAL micro-op reports imm 0 and is popped on its single handshake.
- Flush has the highest priority. It empties the FIFO, resets the pointers and step to 0, and blocks any push that cycle. A concurrent handshake has no effect.
- Push and pop in the same cycle leave the count unchanged. A full FIFO does not accept a push in the same cycle as a pop.

## Timing
- Reset (async assert) values: FIFO empty, pointers 0, step 0, uop_valid_o 0, uop_last_o 0, instr_ready_o 0. uop_class_o, imm_o, pc_o and the register outputs read the empty head and are don't-care, but must not be X.
- After reset deasserts, instr_ready_o = 1 in the first cycle.
- Latency: an instruction pushed at edge N appears at the head (uop_valid_o=1) after edge N. There is no bypass from instr_i to the uop outputs.
- Throughput: one micro-op per cycle. A two-step instruction occupies two handshakes.
- While uop_valid_o=1 and uop_ready_i=0, every uop output holds stable.
- There is no combinational path from uop_ready_i to instr_ready_o.
- Pointers wrap modulo DEPTH. The count ranges 0..DEPTH.

## Test plan
- ADDI x1,x0,5 (0x00500093) at pc 0x100, uop_ready_i=1: one cycle later class 0, rd 1, rs1 0, imm 5, step 0, last 1; popped on the same edge as the handshake.
- JAL x1,+8 (0x008000EF) at 0x200, compressed_i=0: first micro-op class 3, step 0, imm 4, last 0; second micro-op step 1, imm 8, last 1; uop_valid_o=0 afterwards.
- REG_COUNT=16, ADD x16,x0,x0 (0x00000833) -> class 7, illegal_o=1, single step. The same word with REG_COUNT=32 -> class 0, rd 16.
- DEPTH=4, uop_ready_i=0, five back-to-back pushes: four accepted, instr_ready_o=0 on the fifth. Then raise uop_ready_i: FIFO order is preserved and instr_ready_o=1 after the first pop.
- BEQ at step 1 with two more entries queued, flush_i=1 and uop_ready_i=1: next cycle uop_valid_o=0, step 0; the next pushed instruction starts at step 0.
- Assert rst mid-JALR (step 1): outputs take reset values immediately, without waiting for a clock edge; the first instruction after release decodes at step 0.

Source files
------------

// File: rtl/decode_sequencer.sv
// Decode front-end: buffers fetched instructions in a FIFO and expands JUMP/BRANCH into two micro-op steps.
// Head entry decoded combinationally from registered state; outputs hold while uop_ready stays low.
module decode_sequencer #(
    parameter int REG_COUNT = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic [31:0]                  instr_i,
    input  logic [31:0]                  instr_addr_i,
    input  logic                         compressed_i,
    output logic                         uop_valid_o,
    input  logic                         uop_ready_i,
    output logic [2:0]                   uop_class_o,
    output logic                         uop_step_o,
    output logic                         uop_last_o,
    output logic [$clog2(REG_COUNT)-1:0] rs1_o,
    output logic [$clog2(REG_COUNT)-1:0] rs2_o,
    output logic [$clog2(REG_COUNT)-1:0] rd_o,
    output logic [31:0]                  imm_o,
    output logic [31:0]                  pc_o,
    output logic [2:0]                   funct3_o,
    output logic                         illegal_o
);
    localparam int RW = $clog2(REG_COUNT);
    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_JUMP   = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_CSR    = 3'd5;
    localparam logic [2:0] C_SYSTEM = 3'd6;
    localparam logic [2:0] C_ILL    = 3'd7;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        compressed;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          step;

    logic full;
    logic empty;
    logic push;
    logic handshake;

    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign instr_ready_o = !full && !flush_i && !rst;
    assign push          = instr_valid_i && instr_ready_o;
    assign uop_valid_o   = !empty;
    assign handshake     = uop_valid_o && uop_ready_i;

    entry_t      head;
    logic [31:0] ins;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_br, imm_u, imm_j;
    logic [2:0]  cls;
    logic [31:0] imm_a, imm_b;
    logic        two_step;
    logic        use_rd, use_rs1, use_rs2;
    logic        rv32e_bad;

    assign head   = mem[rd_ptr];
    assign ins    = head.instr;
    assign f3     = ins[14:12];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_br = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        cls      = C_ILL;
        imm_a    = '0;
        imm_b    = '0;
        two_step = 1'b0;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (ins[6:0])
            OPC_OP: begin
                cls = C_ALU;
                {use_rd, use_rs1, use_rs2} = 3'b111;
            end
            OPC_OPIMM: begin
                cls   = C_ALU;
                imm_a = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, ins[24:20]} : imm_i;
                {use_rd, use_rs1} = 2'b11;
            end
            OPC_LUI, OPC_AUIPC: begin
                cls    = C_ALU;
                imm_a  = imm_u;
                use_rd = 1'b1;
            end
            OPC_LOAD: begin
                cls   = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ? C_ILL : C_LOAD;
                imm_a = imm_i;
                {use_rd, use_rs1} = 2'b11;
            end
            OPC_STORE: begin
                cls   = (f3 > 3'b010) ? C_ILL : C_STORE;
                imm_a = imm_s;
                {use_rs1, use_rs2} = 2'b11;
            end
            OPC_JAL: begin
                cls      = C_JUMP;
                two_step = 1'b1;
                imm_a    = head.compressed ? 32'd2 : 32'd4;
                imm_b    = imm_j;
                use_rd   = 1'b1;
            end
            OPC_JALR: begin
                cls      = C_JUMP;
                two_step = 1'b1;
                imm_a    = head.compressed ? 32'd2 : 32'd4;
                imm_b    = imm_i;
                {use_rd, use_rs1} = 2'b11;
            end
            OPC_BRANCH: begin
                cls      = (f3 == 3'b010 || f3 == 3'b011) ? C_ILL : C_BRANCH;
                two_step = 1'b1;
                imm_b    = imm_br;
                {use_rs1, use_rs2} = 2'b11;
            end
            OPC_SYSTEM: begin
                if (f3 != 3'b000) begin
                    cls     = (f3 == 3'b100) ? C_ILL : C_CSR;
                    imm_a   = {27'b0, ins[19:15]};
                    use_rd  = 1'b1;
                    // Immediate-form CSR ops reuse the rs1 field as zimm.
                    use_rs1 = !f3[2];
                end else begin
                    cls = (ins[31:20] == 12'h000 || ins[31:20] == 12'h001 ||
                           ins[31:20] == 12'h302) ? C_SYSTEM : C_ILL;
                end
            end
            default: cls = C_ILL;
        endcase

        rv32e_bad = (REG_COUNT == 16) &&
                    ((use_rd && ins[11]) || (use_rs1 && ins[19]) || (use_rs2 && ins[24]));
        if (cls == C_ILL || rv32e_bad) begin
            cls      = C_ILL;
            imm_a    = '0;
            imm_b    = '0;
            two_step = 1'b0;
        end
    end

    assign uop_class_o = cls;
    assign illegal_o   = (cls == C_ILL);
    assign uop_step_o  = step;
    assign uop_last_o  = !empty && (step || !two_step);
    assign imm_o       = step ? imm_b : imm_a;
    assign pc_o        = head.addr;
    assign funct3_o    = f3;
    assign rs1_o       = ins[15 +: RW];
    assign rs2_o       = ins[20 +: RW];
    assign rd_o        = ins[7 +: RW];

    // Storage is cleared on reset so the idle head never decodes from X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            step   <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            step   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {instr_i, instr_addr_i, compressed_i};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (handshake) begin
                if (uop_last_o) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    step   <= 1'b0;
                end else begin
                    step   <= 1'b1;
                end
            end
            case ({push, handshake && uop_last_o})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench: two instances (RV32I and RV32E) share stimulus; a monitor checks every handshake.
module tb_decode_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic        uop_ready = 1'b0;
    logic        compressed = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] instr_addr = '0;

    logic        a_irdy, a_vld, a_step, a_last, a_ill;
    logic [2:0]  a_cls, a_f3;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] a_imm, a_pc;
    logic        b_irdy, b_vld, b_step, b_last, b_ill;
    logic [2:0]  b_cls, b_f3;
    logic [3:0]  b_rs1, b_rs2, b_rd;
    logic [31:0] b_imm, b_pc;

    always #5 clk = ~clk;

    decode_sequencer #(.REG_COUNT(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .instr_valid_i(instr_valid),
        .instr_ready_o(a_irdy), .instr_i(instr), .instr_addr_i(instr_addr),
        .compressed_i(compressed), .uop_valid_o(a_vld), .uop_ready_i(uop_ready),
        .uop_class_o(a_cls), .uop_step_o(a_step), .uop_last_o(a_last),
        .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd), .imm_o(a_imm), .pc_o(a_pc),
        .funct3_o(a_f3), .illegal_o(a_ill));

    decode_sequencer #(.REG_COUNT(16), .DEPTH(4)) dut_e (
        .clk(clk), .rst(rst), .flush_i(flush), .instr_valid_i(instr_valid),
        .instr_ready_o(b_irdy), .instr_i(instr), .instr_addr_i(instr_addr),
        .compressed_i(compressed), .uop_valid_o(b_vld), .uop_ready_i(uop_ready),
        .uop_class_o(b_cls), .uop_step_o(b_step), .uop_last_o(b_last),
        .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd), .imm_o(b_imm), .pc_o(b_pc),
        .funct3_o(b_f3), .illegal_o(b_ill));

    typedef struct {
        logic [2:0]  cls;
        logic        step;
        logic        last;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
        logic [2:0]  f3;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] cls, input logic step, input logic last,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [2:0] f3);
        exp_t e;
        e.cls = cls; e.step = step; e.last = last; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.pc = pc; e.f3 = f3;
        return e;
    endfunction

    task automatic expect2(input exp_t e);
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic check_uop(input string tag, input exp_t e, input logic [4:0] msk,
                             input logic [2:0] cls, input logic step, input logic last,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [2:0] f3,
                             input logic ill);
        chk({tag, "_pc"},    pc,   e.pc);
        chk({tag, "_class"}, {29'b0, cls}, {29'b0, e.cls});
        chk({tag, "_step"},  {31'b0, step}, {31'b0, e.step});
        chk({tag, "_last"},  {31'b0, last}, {31'b0, e.last});
        chk({tag, "_rd"},    {27'b0, rd},  {27'b0, e.rd & msk});
        chk({tag, "_rs1"},   {27'b0, rs1}, {27'b0, e.rs1 & msk});
        chk({tag, "_rs2"},   {27'b0, rs2}, {27'b0, e.rs2 & msk});
        chk({tag, "_imm"},   imm,  e.imm);
        chk({tag, "_funct3"}, {29'b0, f3}, {29'b0, e.f3});
        chk({tag, "_illegal"}, {31'b0, ill}, {31'b0, (e.cls == 3'd7)});
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && !flush && uop_ready) begin
            if (a_vld) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rv32i_unexpected_uop: actual pc=%h required=no uop", a_pc);
                end else begin
                    ea = qa.pop_front();
                    check_uop("rv32i", ea, 5'h1F, a_cls, a_step, a_last, a_rd, a_rs1, a_rs2,
                              a_imm, a_pc, a_f3, a_ill);
                end
            end
            if (b_vld) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rv32e_unexpected_uop: actual pc=%h required=no uop", b_pc);
                end else begin
                    eb = qb.pop_front();
                    check_uop("rv32e", eb, 5'h0F, b_cls, b_step, b_last, {1'b0, b_rd},
                              {1'b0, b_rs1}, {1'b0, b_rs2}, b_imm, b_pc, b_f3, b_ill);
                end
            end
        end
    end

    // Called aligned one time unit after a rising edge; returns with the same alignment.
    task automatic push(input logic [31:0] w, input logic [31:0] a, input logic c);
        int n = 0;
        instr = w; instr_addr = a; compressed = c; instr_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (a_irdy) break;
            n++;
            if (n > 50) begin
                chk("push_ready_timeout", {31'b0, a_irdy}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (qa.size() != 0 || qb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk({nm, "_drain_timeout"}, qa.size(), 32'd0);
                qa.delete(); qb.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("reset_uop_valid",   {31'b0, a_vld},  32'd0);
        chk("reset_uop_last",    {31'b0, a_last}, 32'd0);
        chk("reset_instr_ready", {31'b0, a_irdy}, 32'd0);
        chk("reset_step",        {31'b0, a_step}, 32'd0);
        chk("reset_imm_known",   {31'b0, $isunknown({a_imm, a_pc, a_cls, a_rd})}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_reset_ready",  {31'b0, a_irdy}, 32'd1);
        cyc();

        // Mixed classes with execute always ready.
        uop_ready = 1'b1;
        expect2(mk(3'd0, 0, 1, 5'd1, 5'd0, 5'd5, 32'd5, 32'h100, 3'd0));
        push(32'h00500093, 32'h100, 1'b0);
        expect2(mk(3'd2, 0, 1, 5'd8, 5'd1, 5'd2, 32'd8, 32'h104, 3'd2));
        push(32'h0020A423, 32'h104, 1'b0);
        expect2(mk(3'd5, 0, 1, 5'd1, 5'd2, 5'd0, 32'd2, 32'h108, 3'd1));
        push(32'h300110F3, 32'h108, 1'b0);
        expect2(mk(3'd6, 0, 1, 5'd0, 5'd0, 5'd2, 32'd0, 32'h10C, 3'd0));
        push(32'h30200073, 32'h10C, 1'b0);
        expect2(mk(3'd1, 0, 1, 5'd3, 5'd1, 5'd4, 32'd4, 32'h110, 3'd2));
        push(32'h0040A183, 32'h110, 1'b0);
        expect2(mk(3'd7, 0, 1, 5'd16, 5'd1, 5'd2, 32'd0, 32'h114, 3'd2));
        push(32'h0020A863, 32'h114, 1'b0);
        expect2(mk(3'd3, 0, 0, 5'd1, 5'd0, 5'd8, 32'd4, 32'h200, 3'd0));
        expect2(mk(3'd3, 1, 1, 5'd1, 5'd0, 5'd8, 32'd8, 32'h200, 3'd0));
        push(32'h008000EF, 32'h200, 1'b0);
        drain("jal");
        chk("jal_valid_after", {31'b0, a_vld}, 32'd0);

        // ADD x16: legal on RV32I, illegal on RV32E.
        qa.push_back(mk(3'd0, 0, 1, 5'd16, 5'd0, 5'd0, 32'd0, 32'h204, 3'd0));
        qb.push_back(mk(3'd7, 0, 1, 5'd16, 5'd0, 5'd0, 32'd0, 32'h204, 3'd0));
        push(32'h00000833, 32'h204, 1'b0);
        drain("add_x16");

        // Fill the FIFO while execute stalls.
        uop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr = {12'(i + 1), 5'd0, 3'd0, 5'(i + 2), 7'h13};
            instr_addr = 32'h300 + 32'(4 * i);
            compressed = 1'b0;
            instr_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("fill_ready_%0d", i), {31'b0, a_irdy}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4)
                expect2(mk(3'd0, 0, 1, 5'(i + 2), 5'd0, 5'(i + 1), 32'(i + 1),
                           32'h300 + 32'(4 * i), 3'd0));
            cyc();
        end
        instr_valid = 1'b0;
        uop_ready = 1'b1;
        cyc();
        chk("ready_after_first_pop", {31'b0, a_irdy}, 32'd1);
        drain("fill");

        // Flush while a BEQ sits at step 1 with two entries behind it.
        uop_ready = 1'b0;
        expect2(mk(3'd4, 0, 0, 5'd16, 5'd1, 5'd2, 32'd0, 32'h400, 3'd0));
        push(32'h00208863, 32'h400, 1'b0);
        push(32'h00400213, 32'h404, 1'b0);
        push(32'h00500293, 32'h408, 1'b0);
        uop_ready = 1'b1;
        cyc();
        flush = 1'b1;
        @(negedge clk);
        chk("beq_at_step1", {31'b0, a_step}, 32'd1);
        cyc();
        flush = 1'b0;
        uop_ready = 1'b0;
        chk("flush_valid", {31'b0, a_vld}, 32'd0);
        chk("flush_valid_e", {31'b0, b_vld}, 32'd0);
        chk("flush_step", {31'b0, a_step}, 32'd0);
        uop_ready = 1'b1;
        expect2(mk(3'd0, 0, 1, 5'd6, 5'd0, 5'd7, 32'd7, 32'h500, 3'd0));
        push(32'h00700313, 32'h500, 1'b0);
        drain("post_flush");

        // Asynchronous reset in the middle of a compressed JALR.
        uop_ready = 1'b0;
        expect2(mk(3'd3, 0, 0, 5'd1, 5'd5, 5'd12, 32'd2, 32'h600, 3'd0));
        push(32'h00C280E7, 32'h600, 1'b1);
        uop_ready = 1'b1;
        cyc();
        uop_ready = 1'b0;
        @(negedge clk);
        chk("jalr_at_step1", {31'b0, a_step}, 32'd1);
        chk("jalr_step1_imm", a_imm, 32'd12);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, a_vld},  32'd0);
        chk("async_rst_last",  {31'b0, a_last}, 32'd0);
        chk("async_rst_ready", {31'b0, a_irdy}, 32'd0);
        chk("async_rst_step",  {31'b0, a_step}, 32'd0);
        @(negedge clk); rst = 1'b0;
        cyc();
        uop_ready = 1'b1;
        expect2(mk(3'd0, 0, 1, 5'd1, 5'd0, 5'd5, 32'd5, 32'h700, 3'd0));
        push(32'h00500093, 32'h700, 1'b0);
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
